// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction fetch stage with IF/ID pipeline register.
//
// Holds the PC, issues one request at a time to instruction memory and
// captures returned words into the IF/ID register that decode consumes.
// Honours the decode hazard stall (id_stall) and redirects from resolved
// branches/jumps (ex_take_branch), which take priority in every state.
//
// Ports:
//   clk               system clock
//   rst               synchronous active-low reset (0 at a posedge resets)
//   id_stall          decode hazard; hold the IF/ID register
//   ex_take_branch    redirect request
//   ex_target_pc      redirect target (low two bits forced to zero)
//   proc2Imem_req     fetch request strobe (combinational)
//   proc2Imem_addr    fetch address, valid when proc2Imem_req=1
//   Imem2proc_valid   response strobe, one per request
//   Imem2proc_data    instruction word, valid with Imem2proc_valid
//   if_id_IR          registered instruction to decode
//   if_id_PC          registered PC of if_id_IR
//   if_id_valid_inst  registered; if_id_IR is a real instruction
//   if_state          current FSM state (debug)
//
// Optional feature (macro IF_PERF_CNT_EN):
//   if_fetch_cnt      count of IF/ID loads with valid=1 (wraps at 2^32)
//   if_squash_cnt     count of discarded memory responses (wraps at 2^32)
// -----------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_stall,
  input  logic        ex_take_branch,
  input  logic [31:0] ex_target_pc,
  output logic        proc2Imem_req,
  output logic [31:0] proc2Imem_addr,
  input  logic        Imem2proc_valid,
  input  logic [31:0] Imem2proc_data,
  output logic [31:0] if_id_IR,
  output logic [31:0] if_id_PC,
  output logic        if_id_valid_inst,
  output logic [1:0]  if_state
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] if_fetch_cnt,
  output logic [31:0] if_squash_cnt
`endif
);

  typedef enum logic [1:0] {
    S_REQ    = 2'd0,  // issue a request for pc
    S_WAIT   = 2'd1,  // one request outstanding
    S_HOLD   = 2'd2,  // response parked in the hold buffer while decode stalls
    S_SQUASH = 2'd3   // outstanding response is stale and will be dropped
  } state_e;

  state_e      state, state_n;
  logic [31:0] pc, pc_n, pc_plus4;
  logic [31:0] ir_n, id_pc_n;
  logic        valid_n;
  logic [31:0] hold_ir, hold_pc, hold_ir_n, hold_pc_n;
  logic        back_to_back;

  assign pc_plus4 = pc + 32'd4;  // wraps modulo 2^32

  // A response accepted in WAIT immediately launches the next fetch so a
  // 1-cycle memory sustains one instruction per cycle.
  assign back_to_back   = (state == S_WAIT) && Imem2proc_valid && !id_stall && !ex_take_branch;
  assign proc2Imem_req  = (state == S_REQ) || back_to_back;
  assign proc2Imem_addr = back_to_back ? pc_plus4 : pc;
  assign if_state       = state;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_n   = state;
    pc_n      = pc;
    ir_n      = if_id_IR;
    id_pc_n   = if_id_PC;
    valid_n   = if_id_valid_inst;
    hold_ir_n = hold_ir;
    hold_pc_n = hold_pc;

    if (ex_take_branch) begin
      // Redirect wins over everything, including the stall.
      ir_n      = NOP_INST;
      valid_n   = 1'b0;
      pc_n      = {ex_target_pc[31:2], 2'b00};
      hold_ir_n = '0;
      hold_pc_n = '0;
      unique case (state)
        S_REQ:    state_n = S_SQUASH;  // stale request went out this cycle
        S_WAIT:   state_n = Imem2proc_valid ? S_REQ : S_SQUASH;
        S_HOLD:   state_n = S_REQ;
        // A response landing now ends the outstanding request; staying in
        // SQUASH would wait for a response that never comes.
        S_SQUASH: state_n = Imem2proc_valid ? S_REQ : S_SQUASH;
        default:  state_n = S_REQ;
      endcase
    end else begin
      unique case (state)
        S_REQ: begin
          if (!id_stall) begin
            ir_n    = NOP_INST;
            valid_n = 1'b0;
          end
          state_n = S_WAIT;
        end
        S_WAIT: begin
          if (Imem2proc_valid && !id_stall) begin
            ir_n    = Imem2proc_data;
            id_pc_n = pc;
            valid_n = 1'b1;
            pc_n    = pc_plus4;
          end else if (Imem2proc_valid) begin
            hold_ir_n = Imem2proc_data;
            hold_pc_n = pc;
            state_n   = S_HOLD;
          end else if (!id_stall) begin
            ir_n    = NOP_INST;
            valid_n = 1'b0;
          end
        end
        S_HOLD: begin
          if (!id_stall) begin
            ir_n    = hold_ir;
            id_pc_n = hold_pc;
            valid_n = 1'b1;
            pc_n    = pc_plus4;
            state_n = S_REQ;
          end
        end
        S_SQUASH: begin
          if (!id_stall) begin
            ir_n    = NOP_INST;
            valid_n = 1'b0;
          end
          if (Imem2proc_valid) state_n = S_REQ;  // drop the stale word
        end
        default: state_n = S_REQ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= S_REQ;
      pc               <= RESET_PC;
      if_id_IR         <= NOP_INST;
      if_id_PC         <= '0;
      if_id_valid_inst <= 1'b0;
      // NOTE: the hold buffer is a pair of plain registers, cheap to reset,
      // so it is cleared for deterministic debug visibility.
      hold_ir          <= '0;
      hold_pc          <= '0;
    end else begin
      state            <= state_n;
      pc               <= pc_n;
      if_id_IR         <= ir_n;
      if_id_PC         <= id_pc_n;
      if_id_valid_inst <= valid_n;
      hold_ir          <= hold_ir_n;
      hold_pc          <= hold_pc_n;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic fetch_ev, discard_ev;

  // Valid IF/ID loads happen only on an un-stalled, un-redirected accept.
  assign fetch_ev   = !ex_take_branch && !id_stall &&
                      (((state == S_WAIT) && Imem2proc_valid) || (state == S_HOLD));
  // A response is thrown away in SQUASH, or in WAIT under a redirect.
  assign discard_ev = Imem2proc_valid &&
                      ((state == S_SQUASH) || ((state == S_WAIT) && ex_take_branch));

  always_ff @(posedge clk) begin
    if (!rst) begin
      if_fetch_cnt  <= '0;
      if_squash_cnt <= '0;
    end else begin
      if (fetch_ev)   if_fetch_cnt  <= if_fetch_cnt + 32'd1;
      if (discard_ev) if_squash_cnt <= if_squash_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage.
//
// A transaction-level model tracks the program-order address stream and the
// instruction memory.  Each legitimate request pushes its expected IF/ID
// contents into a scoreboard queue; a redirect empties the queue.  A monitor
// pops and compares on every valid IF/ID load and checks hold/flush/bubble
// behaviour on the other edges.  A second instance with RESET_PC=FFFF_FFFC
// runs against an always-ready 1-cycle memory to cover PC wrap-around.
// -----------------------------------------------------------------------------
module tb_if_stage;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RST_PC_A = 32'h0000_0000;
  localparam logic [31:0] RST_PC_B = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } item_t;

  logic        clk;
  logic        rst;
  logic        id_stall, ex_take_branch;
  logic [31:0] ex_target_pc;
  logic        proc2Imem_req;
  logic [31:0] proc2Imem_addr;
  logic        Imem2proc_valid;
  logic [31:0] Imem2proc_data;
  logic [31:0] if_id_IR, if_id_PC;
  logic        if_id_valid_inst;
  logic [1:0]  if_state;

  logic        id_stall2, ex_take_branch2;
  logic [31:0] ex_target_pc2;
  logic        proc2Imem_req2;
  logic [31:0] proc2Imem_addr2;
  logic        Imem2proc_valid2;
  logic [31:0] Imem2proc_data2;
  logic [31:0] if_id_IR2, if_id_PC2;
  logic        if_id_valid_inst2;
  logic [1:0]  if_state2;

`ifdef IF_PERF_CNT_EN
  logic [31:0] if_fetch_cnt, if_squash_cnt, if_fetch_cnt2, if_squash_cnt2;
`endif

  if_stage #(.RESET_PC(RST_PC_A), .NOP_INST(NOP)) u_dut (
    .clk(clk), .rst(rst), .id_stall(id_stall), .ex_take_branch(ex_take_branch),
    .ex_target_pc(ex_target_pc), .proc2Imem_req(proc2Imem_req),
    .proc2Imem_addr(proc2Imem_addr), .Imem2proc_valid(Imem2proc_valid),
    .Imem2proc_data(Imem2proc_data), .if_id_IR(if_id_IR), .if_id_PC(if_id_PC),
    .if_id_valid_inst(if_id_valid_inst), .if_state(if_state)
`ifdef IF_PERF_CNT_EN
    , .if_fetch_cnt(if_fetch_cnt), .if_squash_cnt(if_squash_cnt)
`endif
  );

  if_stage #(.RESET_PC(RST_PC_B), .NOP_INST(NOP)) u_dut_wrap (
    .clk(clk), .rst(rst), .id_stall(id_stall2), .ex_take_branch(ex_take_branch2),
    .ex_target_pc(ex_target_pc2), .proc2Imem_req(proc2Imem_req2),
    .proc2Imem_addr(proc2Imem_addr2), .Imem2proc_valid(Imem2proc_valid2),
    .Imem2proc_data(Imem2proc_data2), .if_id_IR(if_id_IR2), .if_id_PC(if_id_PC2),
    .if_id_valid_inst(if_id_valid_inst2), .if_state(if_state2)
`ifdef IF_PERF_CNT_EN
    , .if_fetch_cnt(if_fetch_cnt2), .if_squash_cnt(if_squash_cnt2)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Instruction memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'hA5A5_5A5A;
  endfunction

  // ---------------- reference model state ----------------
  item_t       exp_q[$];
  logic [31:0] exp_req;          // next program-order fetch address
  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  logic        mem_killed;       // outstanding request made stale by a redirect
  int          squash_exp;
  int          fetch_seen;
  logic        req2_pend;
  logic [31:0] addr2_pend;
  logic        req_s, req2_s;
  logic [31:0] addr_s, addr2_s;

  // One clock of stimulus.  Inputs change at the negedge; the combinational
  // request is sampled just after and is what the following posedge sees.
  task automatic step(input logic rv, input logic st, input logic br,
                      input logic [31:0] tgt, input int lat);
    logic resp;
    @(negedge clk);
    rst            = rv;
    id_stall       = st;
    ex_take_branch = br;
    ex_target_pc   = tgt;
    resp           = rv && mem_busy && (mem_cnt == 0);
    Imem2proc_valid  = resp;
    Imem2proc_data   = resp ? word_of(mem_addr) : $urandom;
    Imem2proc_valid2 = rv && req2_pend;
    Imem2proc_data2  = word_of(addr2_pend);
    #1;
    req_s   = proc2Imem_req;
    addr_s  = proc2Imem_addr;
    req2_s  = proc2Imem_req2;
    addr2_s = proc2Imem_addr2;
    if (!rv) begin
      mem_busy   = 1'b0;
      mem_killed = 1'b0;
      exp_req    = RST_PC_A;
      exp_q.delete();
      squash_exp = 0;
      req2_pend  = 1'b0;
    end else begin
      if (resp) begin
        if (mem_killed || br) squash_exp++;
        mem_busy = 1'b0;
      end else if (mem_busy) begin
        mem_cnt--;
      end
      if (req_s) begin
        check("req_while_outstanding", {31'b0, mem_busy}, 32'd0);
        mem_busy   = 1'b1;
        mem_cnt    = lat - 1;
        mem_addr   = addr_s;
        mem_killed = br;
        if (!br) begin
          check("req_addr", addr_s, exp_req);
          exp_q.push_back('{pc: exp_req, ir: word_of(exp_req)});
          exp_req = exp_req + 32'd4;
        end
      end
      if (br) begin
        exp_req = {tgt[31:2], 2'b00};
        exp_q.delete();
        if (mem_busy) mem_killed = 1'b1;
      end
      req2_pend  = req2_s;
      addr2_pend = addr2_s;
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // ---------------- monitor ----------------
  logic [31:0] exp_pc2;
  always @(posedge clk) begin
    logic        r_e, st_e, br_e, p_v;
    logic [31:0] p_ir, p_pc;
    item_t       it;
    r_e  = rst;
    st_e = id_stall;
    br_e = ex_take_branch;
    p_ir = if_id_IR;
    p_pc = if_id_PC;
    p_v  = if_id_valid_inst;
    #1;
    if (!r_e) begin
      check("rst_ir", if_id_IR, NOP);
      check("rst_pc", if_id_PC, 32'd0);
      check("rst_valid", {31'b0, if_id_valid_inst}, 32'd0);
      check("rst_state", {30'b0, if_state}, 32'd0);
      check("rst_req", {31'b0, proc2Imem_req}, 32'd1);
      check("rst_addr", proc2Imem_addr, RST_PC_A);
      check("rst_valid2", {31'b0, if_id_valid_inst2}, 32'd0);
      fetch_seen = 0;
      exp_pc2    = RST_PC_B;
    end else begin
      if (br_e) begin
        check("flush_valid", {31'b0, if_id_valid_inst}, 32'd0);
        check("flush_ir", if_id_IR, NOP);
      end else if (st_e) begin
        check("stall_hold_ir", if_id_IR, p_ir);
        check("stall_hold_pc", if_id_PC, p_pc);
        check("stall_hold_valid", {31'b0, if_id_valid_inst}, {31'b0, p_v});
      end else if (if_id_valid_inst) begin
        if (exp_q.size() == 0) begin
          check("unexpected_delivery", if_id_PC, 32'hDEAD_BEEF);
        end else begin
          it = exp_q.pop_front();
          check("deliver_pc", if_id_PC, it.pc);
          check("deliver_ir", if_id_IR, it.ir);
          fetch_seen++;
        end
      end else begin
        check("bubble_ir", if_id_IR, NOP);
      end
      if (if_id_valid_inst2) begin
        check("wrap_pc", if_id_PC2, exp_pc2);
        check("wrap_ir", if_id_IR2, word_of(exp_pc2));
        exp_pc2 = exp_pc2 + 32'd4;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; id_stall = 1'b0; ex_take_branch = 1'b0; ex_target_pc = '0;
    Imem2proc_valid = 1'b0; Imem2proc_data = '0;
    id_stall2 = 1'b0; ex_take_branch2 = 1'b0; ex_target_pc2 = '0;
    Imem2proc_valid2 = 1'b0; Imem2proc_data2 = '0;
    mem_busy = 1'b0; mem_cnt = 0; mem_addr = '0; mem_killed = 1'b0;
    exp_req = RST_PC_A; squash_exp = 0; fetch_seen = 0;
    req2_pend = 1'b0; addr2_pend = '0; exp_pc2 = RST_PC_B;

    step(1'b0, 1'b0, 1'b0, '0, 1);
    step(1'b0, 1'b0, 1'b0, '0, 1);

    // 1-cycle memory: requests 0,4,8 back-to-back; wrap instance 0xFFFFFFFC then 0x0.
    step(1'b1, 1'b0, 1'b0, '0, 1);
    check("t1_req0", {31'b0, req_s}, 32'd1);
    check("t1_wrap_req0", addr2_s, RST_PC_B);
    step(1'b1, 1'b0, 1'b0, '0, 1);
    check("t1_req1", {31'b0, req_s}, 32'd1);
    check("t1_wrap_req1", addr2_s, 32'd0);
    step(1'b1, 1'b0, 1'b0, '0, 1);
    check("t1_req2", {31'b0, req_s}, 32'd1);
    check("t1_req2_addr", addr_s, 32'h8);
    step(1'b1, 1'b0, 1'b0, '0, 1);
    step(1'b1, 1'b0, 1'b0, '0, 3);   // request for 0x10 with 3-cycle latency
    check("t3_req10", addr_s, 32'h10);
    step(1'b1, 1'b0, 1'b0, '0, 3);
    step(1'b1, 1'b1, 1'b0, '0, 3);   // stall begins
    step(1'b1, 1'b1, 1'b0, '0, 3);   // response for 0x10 lands under stall
    after_edge();
    check("t3_hold_state", {30'b0, if_state}, 32'd2);
    check("t3_hold_pc_kept", if_id_PC, 32'hC);
    step(1'b1, 1'b1, 1'b0, '0, 3);
    step(1'b1, 1'b1, 1'b0, '0, 3);
    step(1'b1, 1'b0, 1'b0, '0, 3);   // release
    after_edge();
    check("t3_release_pc", if_id_PC, 32'h10);
    check("t3_release_valid", {31'b0, if_id_valid_inst}, 32'd1);
    step(1'b1, 1'b0, 1'b0, '0, 3);
    check("t3_next_req", addr_s, 32'h14);

    // Redirect to 0x200 while waiting; stale word arrives two cycles later.
    step(1'b1, 1'b0, 1'b1, 32'h200, 3);
    after_edge();
    check("t4_squash_state", {30'b0, if_state}, 32'd3);
    step(1'b1, 1'b0, 1'b0, '0, 3);
    step(1'b1, 1'b0, 1'b0, '0, 3);
    after_edge();
    check("t4_late_word_dropped", if_id_IR, NOP);
    step(1'b1, 1'b0, 1'b0, '0, 1);
    check("t4_target_req", addr_s, 32'h200);
`ifdef IF_PERF_CNT_EN
    after_edge();
    check("t4_squash_cnt", if_squash_cnt, 32'd1);
`endif

    // Redirect to 0x103 together with a response and a stall.
    step(1'b1, 1'b1, 1'b1, 32'h103, 1);
    after_edge();
    check("t5_flush_valid", {31'b0, if_id_valid_inst}, 32'd0);
    step(1'b1, 1'b0, 1'b0, '0, 1);
    check("t5_target_req", addr_s, 32'h100);
    check("t5_target_req_strobe", {31'b0, req_s}, 32'd1);

    // Mid-stream reset.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, '0, 1);
    step(1'b0, 1'b0, 1'b0, '0, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic rv, st, br;
      rv = ($urandom_range(0, 399) != 0);
      st = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 19) == 0);
      step(rv, st, br, $urandom, int'($urandom_range(1, 3)));
    end

    // Drain and check counters.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, '0, 1);
    check("progress", {31'b0, (fetch_seen > 0)}, 32'd1);
`ifdef IF_PERF_CNT_EN
    check("fetch_cnt", if_fetch_cnt, fetch_seen);
    check("squash_cnt", if_squash_cnt, squash_exp);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
